// File: rtl/fifo_umbral_pkg.sv
// Shared definitions for the fifo_umbral family: default geometry, threshold
// reset values, the accept-decision encoding and a depth helper.
// Imported by the interface, the FIFO top and its storage sub-module.
package fifo_umbral_pkg;

    // Default geometry, matching the previous 10-bit x 8-entry FIFO.
    localparam int DATA_W_DEF = 10;
    localparam int ADDR_W_DEF = 3;

    // Threshold values loaded into af/ae registers at reset.
    localparam int AF_RST_DEF = 7;
    localparam int AE_RST_DEF = 1;

    // Per-cycle accept decision, encoded as {wr_acc, rd_acc}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    // Number of entries addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_umbral_if.sv
// Channel-side bundle of one fifo_umbral: write/read requests, data,
// threshold programming and all status outputs.
// master = producer/consumer/control side, slave = the FIFO itself.
interface fifo_umbral_if
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    // requests and programming
    logic              write_enable;
    logic              read_enable;
    logic [DATA_W-1:0] data_in;
    logic              thr_load;
    logic [ADDR_W:0]   umbral_af;
    logic [ADDR_W:0]   umbral_ae;

    // read data and status
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              error;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    modport master (
        output write_enable, read_enable, data_in, thr_load, umbral_af, umbral_ae,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               error, count, wr_ptr, rd_ptr
    );

    modport slave (
        input  write_enable, read_enable, data_in, thr_load, umbral_af, umbral_ae,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               error, count, wr_ptr, rd_ptr
    );

endinterface

// File: rtl/fifo_mem_dp.sv
// Purpose: DATA_W x 2**ADDR_W dual-port storage for fifo_umbral; no control logic.
// Latency: write lands at the posedge of wr_en; rd_data is registered, 1 cycle after rd_en.
// Backpressure: none here; the caller only asserts wr_en/rd_en for accepted operations.
// Ports: clk, reset (sync, active-low, clears rd_data only), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (holds its value when rd_en is low).
module fifo_mem_dp
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Array deliberately has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-address write+read (full FIFO, both accepted) returns the old
    // word, which is the oldest entry the reader is owed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// Purpose: parametrised synchronous FIFO with programmable almost-full/empty thresholds.
// Latency: write-to-read 1 cycle min; data_out/valid_out registered 1 cycle after an accepted read.
// Backpressure: writes dropped when full unless a read is accepted that cycle; reads ignored when empty.
// Ports: clk, reset (sync, active-low), bus (fifo_umbral_if.slave: requests, data, thresholds, status).
// Build option: FIFO_STICKY_ERR_EN makes error sticky until reset; otherwise a 1-cycle pulse per event.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int AF_RST = AF_RST_DEF,
    parameter int AE_RST = AE_RST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    fifo_umbral_if.slave bus
);
    localparam int              DEPTH   = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    // Reset thresholds are clamped like runtime loads so an out-of-range
    // parameter cannot make almost_full unreachable.
    localparam logic [ADDR_W:0] AF_INIT = (AF_RST > DEPTH) ? DEPTH_C : (ADDR_W+1)'(AF_RST);
    localparam logic [ADDR_W:0] AE_INIT = (AE_RST > DEPTH) ? DEPTH_C : (ADDR_W+1)'(AE_RST);

    function automatic logic [ADDR_W:0] clamp_thr(input logic [ADDR_W:0] v);
        return (v > DEPTH_C) ? DEPTH_C : v;
    endfunction

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   af_q;
    logic [ADDR_W:0]   ae_q;
    logic              valid_q;
    logic              error_q;

    logic     full;
    logic     empty;
    logic     wr_acc;
    logic     rd_acc;
    logic     ovf_evt;
    logic     udf_evt;
    logic     err_evt;
    fifo_op_e op;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A full FIFO still takes a write when a read frees a slot in the same
    // cycle; an empty FIFO never serves a read, even alongside a write.
    assign rd_acc = bus.read_enable & ~empty;
    assign wr_acc = bus.write_enable & (~full | rd_acc);
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    assign ovf_evt = bus.write_enable & full & ~rd_acc;
    assign udf_evt = bus.read_enable & empty;
    assign err_evt = ovf_evt | udf_evt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            af_q     <= AF_INIT;
            ae_q     <= AE_INIT;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end

            case (op)
                OP_WR:   count_q <= count_q + (ADDR_W+1)'(1);
                OP_RD:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase

            valid_q <= rd_acc;

`ifdef FIFO_STICKY_ERR_EN
            error_q <= error_q | err_evt;
`else
            error_q <= err_evt;
`endif

            if (bus.thr_load) begin
                af_q <= clamp_thr(bus.umbral_af);
                ae_q <= clamp_thr(bus.umbral_ae);
            end
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.data_out)
    );

    assign bus.valid_out    = valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= af_q);
    assign bus.almost_empty = (count_q <= ae_q);
    assign bus.error        = error_q;
    assign bus.count        = count_q;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral at default geometry (10 bit x 8 entries).
// Expected values are hand-derived constants; error expectations follow FIFO_STICKY_ERR_EN.
module tb_fifo_umbral;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_bad;

`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    fifo_umbral_if #(.DATA_W(10), .ADDR_W(3)) bus ();

    fifo_umbral #(
        .DATA_W (10),
        .ADDR_W (3),
        .AF_RST (7),
        .AE_RST (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given requests; outputs are stable on return.
    task automatic cyc(input logic we, input logic re, input logic [9:0] d);
        bus.write_enable = we;
        bus.read_enable  = re;
        bus.data_in      = d;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.thr_load     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0, 1'b0, 10'h0);
        reset = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.data_in      = '0;
        bus.thr_load     = 1'b0;
        bus.umbral_af    = '0;
        bus.umbral_ae    = '0;

        // ---- 1: reset state, fill 8, drain 8 ----
        do_reset();
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_dout", int'(bus.data_out), 0);
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_wptr", int'(bus.wr_ptr), 0);
        chk("rst_rptr", int'(bus.rd_ptr), 0);
        chk("rst_af", int'(bus.almost_full), 0);
        chk("rst_ae", int'(bus.almost_empty), 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 10'(i));
            chk("t1_wr_count", int'(bus.count), i);
            chk("t1_wr_af", int'(bus.almost_full), (i >= 7) ? 1 : 0);
            chk("t1_wr_full", int'(bus.full), (i == 8) ? 1 : 0);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 10'h0);
            chk("t1_rd_data", int'(bus.data_out), i);
            chk("t1_rd_valid", int'(bus.valid_out), 1);
        end
        chk("t1_end_empty", int'(bus.empty), 1);
        cyc(1'b0, 1'b0, 10'h0);
        chk("t1_idle_valid", int'(bus.valid_out), 0);
        chk("t1_idle_hold", int'(bus.data_out), 8);

        // ---- 2: overflow on full FIFO ----
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'(16 + i));
        cyc(1'b1, 1'b0, 10'h3FF);
        chk("t2_ovf_count", int'(bus.count), 8);
        chk("t2_ovf_err", int'(bus.error), 1);
        cyc(1'b0, 1'b0, 10'h0);
        chk("t2_err_after", int'(bus.error), STICKY ? 1 : 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 10'h0);
            chk("t2_rd_data", int'(bus.data_out), 16 + i);
        end

        // ---- 3: empty, write+read together ----
        cyc(1'b1, 1'b1, 10'h155);
        chk("t3_count", int'(bus.count), 1);
        chk("t3_valid", int'(bus.valid_out), 0);
        chk("t3_err", int'(bus.error), 1);
        cyc(1'b0, 1'b1, 10'h0);
        chk("t3_rd_data", int'(bus.data_out), 10'h155);
        chk("t3_rd_valid", int'(bus.valid_out), 1);
        chk("t3_err_after", int'(bus.error), STICKY ? 1 : 0);

        // ---- 4: full, simultaneous write+read with wr_ptr wrap ----
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 10'h0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 10'h0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'(48 + i));
        chk("t4_full", int'(bus.full), 1);
        chk("t4_wptr_pre", int'(bus.wr_ptr), 7);
        cyc(1'b1, 1'b1, 10'h2AA);
        chk("t4_both_count", int'(bus.count), 8);
        chk("t4_both_data", int'(bus.data_out), 48);
        chk("t4_both_valid", int'(bus.valid_out), 1);
        chk("t4_wptr_wrap", int'(bus.wr_ptr), 0);
        chk("t4_err", int'(bus.error), 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 10'h0);
            chk("t4_rd_data", int'(bus.data_out), (i == 8) ? 10'h2AA : 48 + i);
        end

        // ---- 5: programmable thresholds and clamp ----
        do_reset();
        bus.thr_load  = 1'b1;
        bus.umbral_af = 4'd4;
        bus.umbral_ae = 4'd2;
        cyc(1'b0, 1'b0, 10'h0);
        chk("t5_c0_af", int'(bus.almost_full), 0);
        chk("t5_c0_ae", int'(bus.almost_empty), 1);
        for (int c = 1; c <= 5; c++) begin
            cyc(1'b1, 1'b0, 10'(c));
            chk("t5_af", int'(bus.almost_full), (c >= 4) ? 1 : 0);
            chk("t5_ae", int'(bus.almost_empty), (c <= 2) ? 1 : 0);
        end
        bus.thr_load  = 1'b1;
        bus.umbral_af = 4'd12;
        bus.umbral_ae = 4'd0;
        cyc(1'b0, 1'b0, 10'h0);
        chk("t5_c5_af_clamp", int'(bus.almost_full), 0);
        cyc(1'b1, 1'b0, 10'h6);
        cyc(1'b1, 1'b0, 10'h7);
        chk("t5_c7_af", int'(bus.almost_full), 0);
        cyc(1'b1, 1'b0, 10'h8);
        chk("t5_c8_af", int'(bus.almost_full), 1);

        // ---- 6: reset mid-operation, error pulse vs sticky ----
        do_reset();
        cyc(1'b0, 1'b1, 10'h0);
        chk("t6_udf_err", int'(bus.error), 1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 10'(160 + i));
        chk("t6_count5", int'(bus.count), 5);
        chk("t6_err_held", int'(bus.error), STICKY ? 1 : 0);
        cyc(1'b0, 1'b1, 10'h0);
        chk("t6_pre_rst_data", int'(bus.data_out), 160);
        do_reset();
        chk("t6_rst_count", int'(bus.count), 0);
        chk("t6_rst_empty", int'(bus.empty), 1);
        chk("t6_rst_wptr", int'(bus.wr_ptr), 0);
        chk("t6_rst_rptr", int'(bus.rd_ptr), 0);
        chk("t6_rst_err", int'(bus.error), 0);
        chk("t6_rst_dout", int'(bus.data_out), 0);
        cyc(1'b1, 1'b0, 10'h0AB);
        cyc(1'b0, 1'b1, 10'h0);
        chk("t6_post_data", int'(bus.data_out), 10'h0AB);
        chk("t6_post_empty", int'(bus.empty), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
